// File: rtl/multicycle_core_param.sv
// Parametrised multicycle core: fetch/decode/exec/mem/wb sequencing with an
// internal register file and data memory, single-step, HALT and debug read port.
module multicycle_core_param #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned DMEM_AW = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step_mode,
    input  logic              botao,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_en,
    input  logic [15:0]       imem_data,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              instr_retired,
    input  logic [2:0]        dbg_reg_sel,
    output logic [DATA_W-1:0] dbg_reg_data
);
    localparam int unsigned DMEM_DEPTH = 1 << DMEM_AW;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_WAIT_STEP, S_HALT
    } state_t;

    state_t             state, state_nx;
    logic [15:0]        ir;
    logic [DATA_W-1:0]  regs [8];
    logic [DATA_W-1:0]  dmem [DMEM_DEPTH];
    logic [DATA_W-1:0]  a_q, b_q, d_q, res_q, alu_c;
    logic [PC_W-1:0]    pc_nx, pc_inc, br_off;
    logic               retire;
    logic [1:0]         sync_q;
    logic               prev_q;
    logic               btn_edge;

    logic [3:0]         op;
    logic [2:0]         rd;
    logic [8:0]         imm9;
    logic [11:0]        imm12;
    logic [DMEM_AW-1:0] dmem_addr;

    assign op        = ir[15:12];
    assign rd        = ir[11:9];
    assign imm9      = ir[8:0];
    assign imm12     = ir[11:0];
    assign dmem_addr = a_q[DMEM_AW-1:0];
    assign pc_inc    = pc + PC_W'(1);
    assign br_off    = PC_W'($signed(imm9));
    assign btn_edge  = sync_q[1] & ~prev_q;

    // ALU, including LDI sign extension
    always_comb begin
        alu_c = '0;
        case (op)
            OP_ADD:  alu_c = a_q + b_q;
            OP_SUB:  alu_c = a_q - b_q;
            OP_AND:  alu_c = a_q & b_q;
            OP_OR:   alu_c = a_q | b_q;
            OP_XOR:  alu_c = a_q ^ b_q;
            OP_SHL:  alu_c = {a_q[DATA_W-2:0], 1'b0};
            OP_SHR:  alu_c = {1'b0, a_q[DATA_W-1:1]};
            OP_LDI:  alu_c = DATA_W'($signed(imm9));
            default: alu_c = '0;
        endcase
    end

    // Next state, retire decode and next pc
    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        pc_nx    = pc_inc;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                    OP_SHL, OP_SHR, OP_LDI: state_nx = S_WB;
                    OP_LD, OP_ST:           state_nx = S_MEM;
                    OP_JMP: begin
                        retire = 1'b1;
                        pc_nx  = PC_W'(imm12);
                    end
                    OP_BZ: begin
                        retire = 1'b1;
                        if (d_q == '0) pc_nx = pc_inc + br_off;
                    end
                    OP_HALT: begin
                        retire = 1'b1;
                        pc_nx  = pc;
                    end
                    default: retire = 1'b1;
                endcase
            end
            S_MEM: begin
                if (op == OP_ST) retire = 1'b1;
                else             state_nx = S_WB;
            end
            S_WB:        retire = 1'b1;
            S_WAIT_STEP: if (btn_edge) state_nx = S_FETCH;
            default:     state_nx = S_HALT;
        endcase
        if (retire) begin
            if (op == OP_HALT) state_nx = S_HALT;
            else               state_nx = step_mode ? S_WAIT_STEP : S_FETCH;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    // Datapath registers, register file and button synchroniser
    always_ff @(posedge clock) begin
        if (reset) begin
            pc     <= '0;
            ir     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            res_q  <= '0;
            sync_q <= '0;
            prev_q <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            sync_q <= {sync_q[0], botao};
            prev_q <= sync_q[1];
            if (retire) pc <= pc_nx;
            case (state)
                S_DECODE: begin
                    ir  <= imem_data;
                    a_q <= regs[imem_data[8:6]];
                    b_q <= regs[imem_data[5:3]];
                    d_q <= regs[imem_data[11:9]];
                end
                S_EXEC: res_q <= alu_c;
                S_MEM:  if (op == OP_LD) res_q <= dmem[dmem_addr];
                S_WB:   if (rd != 3'd0) regs[rd] <= res_q;
                default: ;
            endcase
        end
    end

    // Data memory has no reset; a reset in MEM suppresses the store
    always_ff @(posedge clock) begin
        if (!reset && state == S_MEM && op == OP_ST) dmem[dmem_addr] <= b_q;
    end

    assign imem_addr     = pc;
    assign imem_en       = (state == S_FETCH) && !reset;
    assign halted        = (state == S_HALT);
    assign instr_retired = retire && !reset;
    assign dbg_reg_data  = (dbg_reg_sel == 3'd0) ? '0 : regs[dbg_reg_sel];
endmodule

// File: tb/tb_multicycle_core_param.sv
// Bench for multicycle_core_param: directed vector table, random programs
// against an ISA-level model, plus step-mode, HALT and reset-abort sequences.
module tb_multicycle_core_param;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        step_mode = 1'b0;
    logic        botao = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_en;
    logic [15:0] imem_data = 16'h0000;
    logic [7:0]  pc;
    logic        halted;
    logic        instr_retired;
    logic [2:0]  dbg_reg_sel = 3'd0;
    logic [15:0] dbg_reg_data;

    multicycle_core_param #(.DATA_W(16), .PC_W(8), .DMEM_AW(6)) dut (
        .clock(clock), .reset(reset), .step_mode(step_mode), .botao(botao),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
        .pc(pc), .halted(halted), .instr_retired(instr_retired),
        .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data)
    );

    always #5 clock = ~clock;

    logic [15:0] imem [256];
    always @(posedge clock) if (imem_en) imem_data <= imem[imem_addr];

    int n_cmp = 0;
    int n_bad = 0;
    int ret_cnt = 0;
    always @(negedge clock) if (instr_retired) ret_cnt++;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] ins;
        int          lat;
        logic [7:0]  pc_after;
        logic [2:0]  r;
        logic [15:0] val;
    } vec_t;
    vec_t vq[$];

    logic [15:0] m_regs [8];
    logic [15:0] m_dmem [64];
    logic [7:0]  m_pc;

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [8:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] a, input logic [15:0] ins, input int lat,
                           input logic [7:0] pca, input logic [2:0] r, input logic [15:0] v);
        vec_t e;
        e.addr = a; e.ins = ins; e.lat = lat; e.pc_after = pca; e.r = r; e.val = v;
        vq.push_back(e);
    endtask

    task automatic do_reset(input bit check);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        if (check) begin
            chk("reset pc", 32'(pc), 32'h0);
            chk("reset halted", 32'(halted), 32'h0);
            chk("reset retired", 32'(instr_retired), 32'h0);
            chk("reset imem_en", 32'(imem_en), 32'h0);
            for (int i = 1; i < 8; i++) begin
                dbg_reg_sel = 3'(i);
                #1;
                chk($sformatf("reset r%0d", i), 32'(dbg_reg_data), 32'h0);
            end
        end
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("first fetch imem_en", 32'(imem_en), 32'h1);
    endtask

    // Entered at the negedge of an instruction's FETCH cycle; leaves at the next one
    task automatic run_one(input int lat, input logic [7:0] pc_exp, input logic [2:0] r,
                           input logic [15:0] v, input string tag);
        int k;
        k = 1;
        while (!instr_retired && k < 30) begin
            @(negedge clock);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(lat));
        @(negedge clock);
        chk({tag, " pc"}, 32'(pc), 32'(pc_exp));
        dbg_reg_sel = r;
        #1;
        chk({tag, " reg"}, 32'(dbg_reg_data), 32'(v));
    endtask

    // ISA-level reference: executes the instruction at m_pc
    task automatic model_step(output int lat, output bit wr, output logic [2:0] rd);
        logic [15:0] ins;
        int op, a, b, imm, res, nxt;
        ins = imem[m_pc];
        op  = int'(ins[15:12]);
        rd  = ins[11:9];
        a   = int'(m_regs[ins[8:6]]);
        b   = int'(m_regs[ins[5:3]]);
        imm = int'(ins[8:0]);
        if (imm >= 256) imm = imm - 512;
        res = 0;
        wr  = 1'b1;
        lat = 4;
        nxt = int'(m_pc) + 1;
        case (op)
            1:  res = a + b;
            2:  res = a - b;
            3:  res = a & b;
            4:  res = a | b;
            5:  res = a ^ b;
            6:  res = a * 2;
            7:  res = a / 2;
            8:  res = imm;
            9:  begin res = int'(m_dmem[6'(a % 64)]); lat = 5; end
            10: begin m_dmem[6'(a % 64)] = 16'(b); wr = 1'b0; end
            11: begin nxt = int'(ins[11:0]); wr = 1'b0; lat = 3; end
            12: begin
                if (m_regs[rd] == 16'h0) nxt = int'(m_pc) + 1 + imm;
                wr = 1'b0; lat = 3;
            end
            default: begin wr = 1'b0; lat = 3; end
        endcase
        if (wr && rd != 3'd0) m_regs[rd] = 16'(res);
        m_pc = 8'(nxt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k, c0;
        bit wr;
        logic [2:0] r;

        // ---------------- directed vector table ----------------
        add_vec(8'd0,   enc_i(4'h8, 3'd1, 9'd5),        4, 8'd1,  3'd1, 16'h0005);
        add_vec(8'd1,   enc_i(4'h8, 3'd2, 9'h1FD),      4, 8'd2,  3'd2, 16'hFFFD);
        add_vec(8'd2,   enc_r(4'h1, 3'd3, 3'd1, 3'd2),  4, 8'd3,  3'd3, 16'h0002);
        add_vec(8'd3,   enc_i(4'h8, 3'd6, 9'd1),        4, 8'd4,  3'd6, 16'h0001);
        add_vec(8'd4,   enc_r(4'h2, 3'd4, 3'd0, 3'd6),  4, 8'd5,  3'd4, 16'hFFFF);
        add_vec(8'd5,   enc_i(4'h8, 3'd0, 9'd7),        4, 8'd6,  3'd0, 16'h0000);
        add_vec(8'd6,   enc_i(4'h8, 3'd1, 9'd3),        4, 8'd7,  3'd1, 16'h0003);
        add_vec(8'd7,   enc_i(4'h8, 3'd2, 9'h0AA),      4, 8'd8,  3'd2, 16'h00AA);
        add_vec(8'd8,   enc_r(4'hA, 3'd0, 3'd1, 3'd2),  4, 8'd9,  3'd2, 16'h00AA);
        add_vec(8'd9,   enc_i(4'h8, 3'd7, 9'd67),       4, 8'd10, 3'd7, 16'h0043);
        add_vec(8'd10,  enc_i(4'hC, 3'd0, 9'd2),        3, 8'd13, 3'd7, 16'h0043);
        add_vec(8'd13,  enc_r(4'h9, 3'd5, 3'd7, 3'd0),  5, 8'd14, 3'd5, 16'h00AA);
        add_vec(8'd14,  enc_i(4'h8, 3'd1, 9'd5),        4, 8'd15, 3'd1, 16'h0005);
        add_vec(8'd15,  enc_i(4'hC, 3'd1, 9'd2),        3, 8'd16, 3'd1, 16'h0005);
        add_vec(8'd16,  enc_r(4'h5, 3'd2, 3'd1, 3'd5),  4, 8'd17, 3'd2, 16'h00AF);
        add_vec(8'd17,  enc_r(4'h3, 3'd3, 3'd2, 3'd6),  4, 8'd18, 3'd3, 16'h0001);
        add_vec(8'd18,  enc_r(4'h4, 3'd3, 3'd1, 3'd5),  4, 8'd19, 3'd3, 16'h00AF);
        add_vec(8'd19,  enc_r(4'h6, 3'd4, 3'd2, 3'd0),  4, 8'd20, 3'd4, 16'h015E);
        add_vec(8'd20,  enc_r(4'h7, 3'd6, 3'd2, 3'd0),  4, 8'd21, 3'd6, 16'h0057);
        add_vec(8'd21,  enc_i(4'h8, 3'd4, 9'h1FF),      4, 8'd22, 3'd4, 16'hFFFF);
        add_vec(8'd22,  enc_r(4'h1, 3'd4, 3'd4, 3'd6),  4, 8'd23, 3'd4, 16'h0056);
        add_vec(8'd23,  16'h0000,                       3, 8'd24, 3'd4, 16'h0056);
        add_vec(8'd24,  16'hE000,                       3, 8'd25, 3'd0, 16'h0000);
        add_vec(8'd25,  16'hB3FF,                       3, 8'hFF, 3'd5, 16'h00AA);
        add_vec(8'hFF,  enc_r(4'h1, 3'd3, 3'd1, 3'd1),  4, 8'h00, 3'd3, 16'h000A);

        for (int i = 0; i < 256; i++) imem[i] = 16'hD000;
        foreach (vq[i]) imem[vq[i].addr] = vq[i].ins;
        do_reset(1'b1);
        foreach (vq[i]) run_one(vq[i].lat, vq[i].pc_after, vq[i].r, vq[i].val,
                                $sformatf("vec%0d", i));

        // ---------------- random programs vs ISA model ----------------
        reset = 1'b1;
        imem[0] = enc_i(4'h8, 3'd6, 9'd1);
        imem[1] = enc_i(4'h8, 3'd1, 9'd0);
        imem[2] = enc_i(4'h8, 3'd3, 9'h1C0);
        imem[3] = enc_r(4'hA, 3'd0, 3'd1, 3'd1);
        imem[4] = enc_r(4'h1, 3'd1, 3'd1, 3'd6);
        imem[5] = enc_r(4'h1, 3'd3, 3'd3, 3'd6);
        imem[6] = enc_i(4'hC, 3'd3, 9'd1);
        imem[7] = 16'hB003;
        imem[8] = 16'h0000;
        for (int a = 9; a < 256; a++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'hD) rop = 4'h0;
            imem[a] = {rop, 12'($urandom)};
        end
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        for (int i = 0; i < 64; i++) m_dmem[i] = 16'h0;
        m_pc = 8'd0;
        do_reset(1'b0);
        for (int i = 0; i < 430; i++) begin
            model_step(lat, wr, r);
            if (!wr) r = 3'(i % 8);
            run_one(lat, m_pc, r, m_regs[r], $sformatf("rnd%0d", i));
        end

        // ---------------- single-step mode ----------------
        reset = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = enc_i(4'h8, 3'((i % 7) + 1), 9'(i + 16));
        step_mode = 1'b1;
        do_reset(1'b0);
        run_one(4, 8'd1, 3'd1, 16'd16, "step first");
        c0 = ret_cnt;
        repeat (10) @(negedge clock);
        chk("step idle retires", 32'(ret_cnt - c0), 32'h0);
        chk("step idle pc", 32'(pc), 32'h1);
        chk("step idle imem_en", 32'(imem_en), 32'h0);

        botao = 1'b1;
        c0 = ret_cnt;
        k = 0;
        while (!instr_retired && k < 30) begin
            @(negedge clock);
            k++;
        end
        chk("step press latency", 32'(k), 32'd6);
        repeat (50 - k) @(negedge clock);
        chk("step held retires", 32'(ret_cnt - c0), 32'h1);
        chk("step held pc", 32'(pc), 32'h2);
        dbg_reg_sel = 3'd2;
        #1;
        chk("step held r2", 32'(dbg_reg_data), 32'd17);
        botao = 1'b0;
        repeat (5) @(negedge clock);

        c0 = ret_cnt;
        botao = 1'b1;
        @(negedge clock);
        botao = 1'b0;
        repeat (2) @(negedge clock);
        chk("step fetch", 32'(imem_en), 32'h1);
        botao = 1'b1;
        @(negedge clock);
        botao = 1'b0;
        k = 4;
        while (!instr_retired && k < 30) begin
            @(negedge clock);
            k++;
        end
        chk("step glitch latency", 32'(k), 32'd6);
        repeat (15) @(negedge clock);
        chk("step glitch retires", 32'(ret_cnt - c0), 32'h1);
        chk("step glitch pc", 32'(pc), 32'h3);
        step_mode = 1'b0;

        // ---------------- HALT ----------------
        reset = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[0] = enc_i(4'h8, 3'd1, 9'd9);
        imem[1] = 16'hD000;
        imem[2] = enc_i(4'h8, 3'd1, 9'd1);
        do_reset(1'b0);
        run_one(4, 8'd1, 3'd1, 16'd9, "halt ldi");
        c0 = ret_cnt;
        run_one(3, 8'd1, 3'd1, 16'd9, "halt");
        chk("halt pulse count", 32'(ret_cnt - c0), 32'h1);
        chk("halted", 32'(halted), 32'h1);
        c0 = ret_cnt;
        for (int i = 0; i < 10; i++) begin
            botao = ~botao;
            repeat (3) @(negedge clock);
        end
        botao = 1'b0;
        chk("halt no retire", 32'(ret_cnt - c0), 32'h0);
        chk("halt pc frozen", 32'(pc), 32'h1);
        chk("halt held", 32'(halted), 32'h1);
        chk("halt no fetch", 32'(imem_en), 32'h0);

        // ---------------- reset during MEM of ST ----------------
        reset = 1'b1;
        imem[0] = enc_i(4'h8, 3'd1, 9'd5);
        imem[1] = enc_i(4'h8, 3'd2, 9'h011);
        imem[2] = enc_r(4'hA, 3'd0, 3'd1, 3'd2);
        imem[3] = enc_i(4'h8, 3'd2, 9'h055);
        imem[4] = enc_r(4'hA, 3'd0, 3'd1, 3'd2);
        do_reset(1'b0);
        run_one(4, 8'd1, 3'd1, 16'h0005, "rst ldi r1");
        run_one(4, 8'd2, 3'd2, 16'h0011, "rst ldi r2");
        run_one(4, 8'd3, 3'd2, 16'h0011, "rst st1");
        run_one(4, 8'd4, 3'd2, 16'h0055, "rst ldi r2b");
        repeat (3) @(negedge clock);
        chk("rst in st mem", 32'(halted | imem_en), 32'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst abort pc", 32'(pc), 32'h0);
        chk("rst abort halted", 32'(halted), 32'h0);
        dbg_reg_sel = 3'd1;
        #1;
        chk("rst abort r1", 32'(dbg_reg_data), 32'h0);
        imem[1] = enc_r(4'h9, 3'd3, 3'd1, 3'd0);
        imem[2] = 16'hD000;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst refetch", 32'(imem_en), 32'h1);
        run_one(4, 8'd1, 3'd1, 16'h0005, "rst reload r1");
        run_one(5, 8'd2, 3'd3, 16'h0011, "rst ld kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
